// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : alu_pkg                                                          |
// | Purpose : Shared ALU definitions: opcode encoding, data width and the      |
// |           opcode driven onto the ALU when no command is being issued.      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package alu_pkg;

  localparam int ALU_DATA_W = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4
  } alu_op_e;

  // AND of two zero operands keeps the ALU datapath quiet during idle slots.
  localparam alu_op_e ALU_IDLE_OP = ALU_AND;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_driver_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_cmd_driver_fifo                                              |
// | Purpose : Synchronous show-ahead FIFO with registered storage. The head    |
// |           entry is visible on head_data whenever empty is low.             |
// | Ports   : clk, rst (async, active-high)                                    |
// |           push, push_data  - write side                                    |
// |           pop, head_data   - read side (pop advances the head)             |
// |           count, empty     - occupancy                                     |
// | Params  : WIDTH entry width, DEPTH entries (power of 2, >= 2)              |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module alu_cmd_driver_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign head_data = mem[rd_ptr];

  // Storage is cleared on reset so the read port shows zero after reset.
  // Pointers are exactly log2(DEPTH) wide, so increments wrap modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The credit scheme upstream guarantees neither of these ever happens.
  a_no_pop_empty : assert property (@(posedge clk) disable iff (rst) !(pop && empty));
  a_no_push_full : assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule
`default_nettype wire

// File: rtl/alu_cmd_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_cmd_driver                                                   |
// | Purpose : Initiator for a registered 32-bit ALU. Accepts tagged commands   |
// |           (valid/ready), drives A/B/Opcode into the ALU, captures          |
// |           Result/Error one cycle later and returns in-order tagged         |
// |           responses through a buffered valid/ready port.                   |
// | Ports   : clk, rst (async, active-high, shared with ALU)                   |
// |           cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op/cmd_tag - command in      |
// |           alu_a/alu_b/alu_opcode (registered), alu_result/alu_error - ALU  |
// |           rsp_valid/rsp_ready/rsp_result/rsp_error/rsp_tag - response out  |
// |           stat_issued/stat_errors - only with ALU_CMD_DRIVER_STATS_EN      |
// | Macro   : ALU_CMD_DRIVER_STATS_EN adds saturating 16-bit counters of       |
// |           accepted commands and of responses captured with error=1.        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int TAG_W     = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ALU_DATA_W-1:0] cmd_a,
  input  logic [ALU_DATA_W-1:0] cmd_b,
  input  logic [2:0]            cmd_op,
  input  logic [TAG_W-1:0]      cmd_tag,
  output logic [ALU_DATA_W-1:0] alu_a,
  output logic [ALU_DATA_W-1:0] alu_b,
  output logic [2:0]            alu_opcode,
  input  logic [ALU_DATA_W-1:0] alu_result,
  input  logic                  alu_error,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ALU_DATA_W-1:0] rsp_result,
  output logic                  rsp_error,
  output logic [TAG_W-1:0]      rsp_tag
`ifdef ALU_CMD_DRIVER_STATS_EN
  ,
  output logic [15:0]           stat_issued,
  output logic [15:0]           stat_errors
`endif
);

  localparam int CNT_W  = $clog2(RSP_DEPTH) + 1;
  localparam int USED_W = CNT_W + 1;
  localparam int ENT_W  = TAG_W + 1 + ALU_DATA_W;

  logic              s0_vld;
  logic [TAG_W-1:0]  s0_tag;
  logic              s1_vld;
  logic [TAG_W-1:0]  s1_tag;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [ENT_W-1:0]  fifo_head;
  logic [USED_W-1:0] credits_used;
  logic              accept;
  logic              push;
  logic              pop;

  // Every command in flight owns a FIFO slot in advance, so the FIFO can never
  // overflow. Only registered state feeds cmd_ready.
  assign credits_used = USED_W'(fifo_count) + USED_W'(s0_vld) + USED_W'(s1_vld);
  assign cmd_ready    = (credits_used < USED_W'(RSP_DEPTH));
  assign accept       = cmd_valid & cmd_ready;

  // S0: issue registers feeding the ALU. Idle slots drive AND 0,0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= 3'(ALU_IDLE_OP);
      s0_vld     <= 1'b0;
      s0_tag     <= '0;
    end else if (accept) begin
      alu_a      <= cmd_a;
      alu_b      <= cmd_b;
      alu_opcode <= cmd_op;
      s0_vld     <= 1'b1;
      s0_tag     <= cmd_tag;
    end else begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= 3'(ALU_IDLE_OP);
      s0_vld     <= 1'b0;
    end
  end

  // S1: mirrors the ALU's own output register; the tag rides with the valid bit
  // so the captured result is paired with the command that produced it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1_tag <= '0;
    end else begin
      s1_vld <= s0_vld;
      s1_tag <= s0_tag;
    end
  end

  assign push      = s1_vld;
  assign rsp_valid = !fifo_empty;
  assign pop       = rsp_valid & rsp_ready;

  alu_cmd_driver_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({s1_tag, alu_error, alu_result}),
    .pop       (pop),
    .head_data (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  assign {rsp_tag, rsp_error, rsp_result} = fifo_head;

`ifdef ALU_CMD_DRIVER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued <= '0;
      stat_errors <= '0;
    end else begin
      if (accept && (stat_issued != 16'hFFFF)) begin
        stat_issued <= stat_issued + 1'b1;
      end
      if (push && alu_error && (stat_errors != 16'hFFFF)) begin
        stat_errors <= stat_errors + 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_driver.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_alu_cmd_driver                                                |
// | Purpose : Self-checking bench for alu_cmd_driver. Contains a behavioural   |
// |           registered ALU, a reference model feeding an expected-response   |
// |           queue, and a monitor that checks every consumed response.        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_alu_cmd_driver;

  localparam int TAG_W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic [2:0]  cmd_op = '0;
  logic [3:0]  cmd_tag = '0;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_opcode;
  logic [31:0] alu_result;
  logic        alu_error;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic        rsp_error;
  logic [3:0]  rsp_tag;
`ifdef ALU_CMD_DRIVER_STATS_EN
  logic [15:0] stat_issued;
  logic [15:0] stat_errors;
`endif

  alu_cmd_driver #(.TAG_W(TAG_W), .RSP_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .cmd_tag    (cmd_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_error  (alu_error),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_error  (rsp_error),
    .rsp_tag    (rsp_tag)
`ifdef ALU_CMD_DRIVER_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_errors (stat_errors)
`endif
  );

  always #5 clk = ~clk;

  // ALU semantics: signed overflow on ADD/SUB and undefined opcodes raise Error.
  function automatic logic [32:0] alu_eval(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa;
    longint sb;
    longint full;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin
        full = sa + sb;
        return {(full > 64'sd2147483647) || (full < -64'sd2147483648), 32'(full)};
      end
      3'd1: begin
        full = sa - sb;
        return {(full > 64'sd2147483647) || (full < -64'sd2147483648), 32'(full)};
      end
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // Behavioural registered ALU sharing the driver's reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_result <= '0;
      alu_error  <= 1'b0;
    end else begin
      {alu_error, alu_result} <= alu_eval(alu_opcode, alu_a, alu_b);
    end
  end

  typedef struct {
    logic [31:0] res;
    logic        err;
    logic [3:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_accepted = 0;
  int   exp_issued = 0;
  int   exp_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Issue one command; expectation is queued on the cycle it is seen accepted.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input logic [3:0] tag);
    exp_t e;
    logic [32:0] r;
    bit   ok;
    int   waited;
    ok = 1'b0;
    waited = 0;
    cmd_valid = 1'b1;
    cmd_a = a;
    cmd_b = b;
    cmd_op = op;
    cmd_tag = tag;
    while (!ok && waited < 200) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        r = alu_eval(op, a, b);
        e.res = r[31:0];
        e.err = r[32];
        e.tag = tag;
        exp_q.push_back(e);
        n_accepted++;
        exp_issued++;
        if (r[32]) exp_errors++;
      end
      @(posedge clk);
      #1;
      waited++;
    end
    cmd_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: tag %0d not accepted within 200 cycles", tag);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check({name, "_idle"}, 64'(rsp_valid), 64'd0);
  endtask

  // Monitor: compares every consumed response with the queue head and checks
  // that a stalled response holds steady.
  logic        stalled = 1'b0;
  logic [36:0] held;
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (stalled) check("rsp_stable", {rsp_tag, rsp_error, rsp_result}, held);
      if (rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", {rsp_tag, rsp_error, rsp_result}, 64'h1_DEAD_BEEF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_tag", rsp_tag, e.tag);
          check("rsp_result", rsp_result, e.res);
          check("rsp_error", rsp_error, e.err);
        end
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = {rsp_tag, rsp_error, rsp_result};
      end
    end else begin
      stalled = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  bit rand_done;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_alu_opcode", alu_opcode, 3'b010);
    check("reset_alu_ab", {alu_a, alu_b}, 64'd0);
    check("reset_rsp_fields", {rsp_tag, rsp_error, rsp_result}, 64'd0);
    @(posedge clk);
    #1;

    // ADD 5+7 with latency observation (rsp_ready held low)
    issue(32'd5, 32'd7, 3'd0, 4'd3);
    @(negedge clk);
    check("latency_after_e0", rsp_valid, 0);
    @(negedge clk);
    check("latency_after_e1", rsp_valid, 0);
    @(negedge clk);
    check("latency_after_e2", rsp_valid, 1);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    drain("drain_add");

    // Overflow and undefined opcode
    issue(32'h7FFF_FFFF, 32'd1, 3'd0, 4'd1);
    issue(32'h0000_FFFF, 32'h0000_FFFF, 3'b110, 4'd2);
    drain("drain_err");

    // Credit limit: 6 commands with rsp_ready low, exactly 4 accepted
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    n_accepted = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          issue($urandom, $urandom, 3'(4 - (i % 3)), 4'(i));
        end
      end
      begin
        repeat (15) @(negedge clk);
        check("credit_accepted", 64'(n_accepted), 64'd4);
        check("credit_cmd_ready", cmd_ready, 0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
      end
    join
    drain("drain_credit");

    // Reset with commands buffered and in flight
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    issue(32'd10, 32'd20, 3'd0, 4'd6);
    issue(32'd30, 32'd5, 3'd1, 4'd7);
    issue(32'hF0F0, 32'h0FF0, 3'd3, 4'd8);
    check("pre_reset_rsp_valid", rsp_valid, 1);
    rst = 1'b1;
    exp_q.delete();
    exp_issued = 0;
    exp_errors = 0;
    #1;
    check("mid_reset_rsp_valid", rsp_valid, 0);
    check("mid_reset_cmd_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_opcode", alu_opcode, 3'b010);
    check("post_reset_rsp_valid", rsp_valid, 0);
    rsp_ready = 1'b1;
    issue(32'd100, 32'd23, 3'd1, 4'd9);
    issue(32'hAAAA_5555, 32'hFFFF_0000, 3'd4, 4'd10);
    drain("drain_post_reset");

    // Randomized traffic with random backpressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          issue(rand_operand(), rand_operand(), 3'($urandom_range(0, 7)), 4'($urandom));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
        rsp_ready = 1'b1;
      end
    join
    drain("drain_random");

`ifdef ALU_CMD_DRIVER_STATS_EN
    check("stat_issued", stat_issued, 64'(exp_issued));
    check("stat_errors", stat_errors, 64'(exp_errors));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
